// File: rtl/rotate_pkg.sv
// Shared types and constants for the rotate sweep sequencer.
package rotate_pkg;
  localparam int DEF_DATA_W = 8;

  localparam logic DIR_RIGHT = 1'b0;
  localparam logic DIR_LEFT  = 1'b1;

  typedef enum logic {IDLE, RUN} sweep_state_t;
endpackage

// File: rtl/rotate_core.sv
// Combinational barrel rotate: right or left by amt (modulo DATA_W).
module rotate_core
  import rotate_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int AMT_W  = $clog2(DATA_W)
) (
  input  logic [DATA_W-1:0] data,
  input  logic [AMT_W-1:0]  amt,
  input  logic              lr,
  output logic [DATA_W-1:0] rot
);
  logic [2*DATA_W-1:0] dd, shr, shl;

  // Shift a doubled copy so bits wrap around; amount 0 passes data through.
  always_comb begin
    dd  = {data, data};
    shr = dd >> amt;
    shl = dd << amt;
    rot = (lr == DIR_LEFT) ? shl[2*DATA_W-1:DATA_W] : shr[DATA_W-1:0];
  end
endmodule

// File: rtl/rotate_sweep_sequencer.sv
// Rotate sweep sequencer: takes one command (byte, direction, count) and
// emits the byte rotated by 0..count-1 on successive beats, with backpressure.
// Optional feature: define SWEEP_PARITY_EN to add the out_parity port.
module rotate_sweep_sequencer
  import rotate_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int AMT_W  = $clog2(DATA_W)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_lr,
  input  logic [AMT_W:0]    in_count,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [AMT_W-1:0]  out_amt,
  output logic              out_last,
  output logic              busy
`ifdef SWEEP_PARITY_EN
  ,
  output logic              out_parity
`endif
);
  localparam logic [AMT_W:0]   FULL_CNT = (AMT_W+1)'(DATA_W);
  localparam logic [AMT_W:0]   CNT_ONE  = (AMT_W+1)'(1);
  localparam logic [AMT_W-1:0] AMT_ONE  = AMT_W'(1);

  sweep_state_t      state;
  logic [DATA_W-1:0] data_reg;
  logic              lr_reg;
  logic [AMT_W-1:0]  amt_reg;
  logic [AMT_W:0]    cnt_reg;

  logic [AMT_W:0]    norm_cnt;
  logic              last_beat;
  logic              run;
  logic [DATA_W-1:0] rot;

  // Zero or oversize counts mean a full sweep of DATA_W beats.
  always_comb begin
    norm_cnt = in_count;
    if (in_count == '0 || in_count > FULL_CNT) norm_cnt = FULL_CNT;
  end

  assign last_beat = ({1'b0, amt_reg} == (cnt_reg - CNT_ONE));
  assign run       = (state == RUN);

  rotate_core #(.DATA_W(DATA_W), .AMT_W(AMT_W)) u_core (
    .data (data_reg),
    .amt  (amt_reg),
    .lr   (lr_reg),
    .rot  (rot)
  );

  // Outputs come straight from state registers, so they hold during stalls.
  assign in_ready  = (state == IDLE) & ~reset;
  assign out_valid = run;
  assign busy      = run;
  assign out_data  = run ? rot : '0;
  assign out_amt   = run ? amt_reg : '0;
  assign out_last  = run & last_beat;
`ifdef SWEEP_PARITY_EN
  assign out_parity = run & (^rot);
`endif

  // Command latch and beat stepping; a transfer of the last beat ends the sweep.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      data_reg <= '0;
      lr_reg   <= 1'b0;
      amt_reg  <= '0;
      cnt_reg  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            data_reg <= in_data;
            lr_reg   <= in_lr;
            cnt_reg  <= norm_cnt;
            amt_reg  <= '0;
            state    <= RUN;
          end
        end
        RUN: begin
          if (out_ready) begin
            if (last_beat) state <= IDLE;
            else           amt_reg <= amt_reg + AMT_ONE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_rotate_sweep_sequencer.sv
// Self-checking bench for rotate_sweep_sequencer against a bit-by-bit
// rotation model and a beat-index scoreboard.
module tb_rotate_sweep_sequencer;
  localparam int DATA_W = 8;
  localparam int AMT_W  = 3;

  logic              clk = 1'b0;
  logic              reset;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic              in_lr;
  logic [AMT_W:0]    in_count;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic [AMT_W-1:0]  out_amt;
  logic              out_last;
  logic              busy;
`ifdef SWEEP_PARITY_EN
  logic              out_parity;
`endif

  int checks = 0;
  int errors = 0;

  rotate_sweep_sequencer #(.DATA_W(DATA_W), .AMT_W(AMT_W)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_lr     (in_lr),
    .in_count  (in_count),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_amt   (out_amt),
    .out_last  (out_last),
    .busy      (busy)
`ifdef SWEEP_PARITY_EN
    ,
    .out_parity(out_parity)
`endif
  );

  always #5 clk = ~clk;

  // Rotate one bit position at a time, a times.
  function automatic logic [DATA_W-1:0] rot_model(input logic [DATA_W-1:0] d,
                                                  input logic lr, input int a);
    logic [DATA_W-1:0] r;
    r = d;
    for (int i = 0; i < a; i++) begin
      if (lr) r = {r[DATA_W-2:0], r[DATA_W-1]};
      else    r = {r[0], r[DATA_W-1:1]};
    end
    return r;
  endfunction

  function automatic int beats_of(input int c);
    return (c == 0 || c > DATA_W) ? DATA_W : c;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // mode 0: out_ready high; 1: random out_ready; 2: 3-cycle stall at beat 1.
  // noisy: keep in_valid high during the sweep with another command (nd/nlr/nc).
  task automatic run_cmd(input logic [DATA_W-1:0] d, input logic lr, input int c,
                         input int mode, input bit noisy,
                         input logic [DATA_W-1:0] nd, input logic nlr, input int nc);
    int k, idx, cyc, stall;
    logic [DATA_W-1:0] exp_d;
    k = beats_of(c);
    cyc = 0;
    while (in_ready !== 1'b1 && cyc < 20) begin step(); cyc++; end
    chk("cmd_in_ready", in_ready, 1);
    in_data = d; in_lr = lr; in_count = c[AMT_W:0]; in_valid = 1'b1;
    step();
    if (noisy) begin
      in_data = nd; in_lr = nlr; in_count = nc[AMT_W:0]; in_valid = 1'b1;
    end else begin
      in_valid = 1'b0; in_data = DATA_W'($urandom); in_lr = 1'($urandom);
      in_count = (AMT_W+1)'($urandom);
    end
    idx = 0; stall = 0; cyc = 0;
    while (idx < k && cyc < 200) begin
      case (mode)
        0:       out_ready = 1'b1;
        1:       out_ready = 1'($urandom_range(0, 1));
        default: if (idx == 1 && stall < 3) begin out_ready = 1'b0; stall++; end
                 else out_ready = 1'b1;
      endcase
      exp_d = rot_model(d, lr, idx);
      chk("out_valid", out_valid, 1);
      chk("busy", busy, 1);
      chk("in_ready_run", in_ready, 0);
      chk("out_data", out_data, exp_d);
      chk("out_amt", out_amt, idx);
      chk("out_last", out_last, (idx == k - 1));
`ifdef SWEEP_PARITY_EN
      chk("out_parity", out_parity, $countones(exp_d) % 2);
`endif
      step();
      if (out_ready) idx++;
      cyc++;
    end
    if (idx < k) chk("sweep_timeout", idx, k);
    chk("idle_in_ready", in_ready, 1);
    chk("idle_out_valid", out_valid, 0);
    chk("idle_busy", busy, 0);
`ifdef SWEEP_PARITY_EN
    chk("idle_parity", out_parity, 0);
`endif
  endtask

  initial begin
    reset = 1'b1; in_valid = 1'b0; in_data = '0; in_lr = 1'b0; in_count = '0;
    out_ready = 1'b0;
    #1;
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_amt", out_amt, 0);
    chk("rst_out_last", out_last, 0);
    step(); step();
    reset = 1'b0;
    #1;
    chk("post_rst_in_ready", in_ready, 1);

    // Basic right sweep, full left sweep via count 0, stall at beat 1.
    run_cmd(8'hED, 1'b0, 4, 0, 1'b0, 8'h00, 1'b0, 0);
    run_cmd(8'hED, 1'b1, 0, 0, 1'b0, 8'h00, 1'b0, 0);
    run_cmd(8'hED, 1'b0, 3, 2, 1'b0, 8'h00, 1'b0, 0);

    // in_valid held through RUN: ignored, then accepted once in IDLE.
    run_cmd(8'h5A, 1'b1, 2, 0, 1'b1, 8'h3C, 1'b0, 3);
    run_cmd(8'h3C, 1'b0, 3, 0, 1'b0, 8'h00, 1'b0, 0);
    step();
    chk("no_repeat_accept", out_valid, 0);

    // Oversize count behaves like a full sweep.
    run_cmd(8'h01, 1'b0, 9, 1, 1'b0, 8'h00, 1'b0, 0);

    // Reset in the middle of an 8-beat sweep.
    in_data = 8'hED; in_lr = 1'b0; in_count = '0; in_valid = 1'b1;
    step();
    in_valid = 1'b0; out_ready = 1'b1;
    step(); step();
    chk("mid_amt_before_rst", out_amt, 2);
    out_ready = 1'b0;
    reset = 1'b1;
    #1;
    chk("mid_rst_out_valid", out_valid, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_in_ready", in_ready, 0);
    chk("mid_rst_out_data", out_data, 0);
    chk("mid_rst_out_last", out_last, 0);
    step();
    reset = 1'b0;
    #1;
    chk("mid_rst_release_ready", in_ready, 1);
    run_cmd(8'h81, 1'b1, 2, 0, 1'b0, 8'h00, 1'b0, 0);

    // Randomized commands under random backpressure.
    for (int n = 0; n < 12; n++)
      run_cmd(DATA_W'($urandom), 1'($urandom), $urandom_range(0, 15), 1, 1'b0,
              8'h00, 1'b0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/rotate_sweep_sequencer.md
Name: rotate_sweep_sequencer

Overview:
- Streaming sequencer that drives the 8-bit rotate datapath.
- Accepts one command (byte, direction, rotation count) over a valid/ready handshake.
- Emits the byte rotated by amounts 0, 1, … count-1 on successive output beats, each tagged with its amount, with output backpressure honoured.
- Replaces hand-written amount-sweep stimulus; feeds UART/LED display logic downstream.

Parameters:
- DATA_W, 8, data width in bits (power of two, ≥2).
- AMT_W, $clog2(DATA_W), width of rotation amount.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- in_valid  input  1  command valid.
- in_ready  output  1  sequencer can accept a command.
- in_data  input  DATA_W  byte to rotate.
- in_lr  input  1  direction: 0 = rotate right, 1 = rotate left.
- in_count  input  AMT_W+1  number of beats to emit. 0 or >DATA_W is treated as DATA_W.
- out_valid  output  1  result beat valid.
- out_ready  input  1  downstream accepts beat.
- out_data  output  DATA_W  rotated byte.
- out_amt  output  AMT_W  rotation amount of this beat.
- out_last  output  1  final beat of the command.
- busy  output  1  command in progress.

Behaviour:
- Single clock domain (clk). Reset is asynchronous, active-high (reset).
- Reset values:
  - state=IDLE.
  - in_ready=1 after reset deasserts. in_ready is 0 while reset is high.
  - out_valid=0, out_data=0, out_amt=0, out_last=0, busy=0.
  - Internal data_reg, lr_reg, amt_reg, cnt_reg = 0.
- FSM states: IDLE, RUN.
- IDLE:
  - in_ready=1, out_valid=0.
  - When in_valid is high at a rising edge: latch data_reg=in_data, lr_reg=in_lr, cnt_reg=normalised count, amt_reg=0. Go to RUN.
- RUN:
  - in_ready=0, busy=1, out_valid=1.
  - out_data = rotate(data_reg, amt_reg, lr_reg), combinational from registers only.
  - out_amt=amt_reg; out_last=(amt_reg==cnt_reg-1).
- Beat transfer occurs on out_valid && out_ready at a rising edge:
  - If out_last: go to IDLE. in_ready=1 on the next cycle.
  - Otherwise: amt_reg+1.
- Stall: when out_ready=0, all outputs hold stable. No beat is dropped or repeated.
- Latency: command accepted at edge N → first beat valid in cycle N+1.
  - Full sweep of k beats with out_ready tied high takes k cycles.
  - One idle cycle separates commands (minimum k+1 cycles per command).
- Rotation arithmetic: amount taken modulo DATA_W. Amount 0 returns data unchanged.
  - Right: out = {d[a-1:0], d[DATA_W-1:a]}.
  - Left: out = {d[DATA_W-1-a:0], d[DATA_W-1:DATA_W-a]}.
- Count normalisation: in_count==0 or in_count>DATA_W gives cnt_reg=DATA_W. amt_reg therefore never exceeds DATA_W-1.
- in_valid in RUN is ignored; the command is not consumed.
- in_data, in_lr and in_count may change freely after acceptance.
- Reset mid-sweep aborts immediately. All outputs return to reset values. No partial beat is completed.

Optional Feature:
- Macro SWEEP_PARITY_EN.
- Defined: adds output port out_parity (1 bit) = even parity (^out_data) of the current beat. It is valid with out_valid, 0 in reset/IDLE, and holds with the data during stall.
- Undefined: port and logic absent. All other behaviour identical.

Decomposition:
- Package rotate_pkg:
  - typedef enum logic {IDLE, RUN} sweep_state_t.
  - Constants DIR_RIGHT=1'b0, DIR_LEFT=1'b1.
  - Default DATA_W=8.
- Sub-module rotate_core (purely combinational): inputs data, amt, lr; output rotated data. Instantiated once.
- Sequencer holds FSM, registers, handshake.

Test Plan:
- Reset, then command 0xED, lr=0, count=4, out_ready=1 → beats ED/0, F6/1, 7B/2, BD/3; out_last only on amt 3; in_ready=1 one cycle after last beat.
- 0xED, lr=1, count=0 → 8 beats ED, DB, B7, 6F, DE, BD, 7B, F6 (amt 0..7); out_last on amt 7.
- 0xED, lr=0, count=3; out_ready low for 3 cycles at beat amt=1 → F6/1 held stable throughout stall; sequence resumes 7B/2; no duplicates.
- Pulse in_valid with a second command during RUN → ignored. in_valid held into IDLE → accepted exactly once.
- Assert reset during beat amt=2 of an 8-beat sweep → out_valid=0, busy=0 immediately; a new command 0x81, lr=1, count=2 gives 81, 03.
- With SWEEP_PARITY_EN: 0xED right sweep → out_parity=0 on every beat (six ones). Command 0x01 → out_parity=1.
